// File: rtl/srt_div_ctrl.sv
// Sequencing FSM for the radix-2 SRT binary32 divider: latches operands, then runs normalize, ITERS digit steps, fix-up, result.
// Latency: out_valid ITERS+3 cycles after accept (2 for zero/div-by-zero); holds result until out_ready, flush aborts from any busy state.
module srt_div_ctrl #(
   parameter int ITERS = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] opa_q,
   output logic [31:0] opb_q,
   input  logic        flush,
   output logic        norm_load,
   output logic        iter_en,
   output logic        iter_first,
   output logic [5:0]  iter_idx,
   input  logic        rem_neg,
   output logic        corr_en,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        res_div_zero,
   output logic        res_zero,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_NORM,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [5:0] LAST_IDX = 6'(ITERS - 1);

   state_t     state;
   logic [5:0] cnt;
   logic       opa_zero;
   logic       opb_zero;

   // Sign bit is ignored: both +0 and -0 count as zero.
   assign opa_zero = (opa_q[30:0] == 31'd0);
   assign opb_zero = (opb_q[30:0] == 31'd0);

   // The correction decision depends on the remainder sign seen in FIX itself.
   assign corr_en = (state == S_FIX) && rem_neg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         opa_q        <= '0;
         opb_q        <= '0;
         in_ready     <= 1'b1;
         busy         <= 1'b0;
         norm_load    <= 1'b0;
         iter_en      <= 1'b0;
         iter_first   <= 1'b0;
         iter_idx     <= '0;
         out_valid    <= 1'b0;
         res_zero     <= 1'b0;
         res_div_zero <= 1'b0;
      end else begin
         norm_load  <= 1'b0;
         iter_en    <= 1'b0;
         iter_first <= 1'b0;
         iter_idx   <= '0;

         if (flush && (state != S_IDLE)) begin
            state        <= S_IDLE;
            cnt          <= '0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            res_zero     <= 1'b0;
            res_div_zero <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (in_valid && !flush) begin
                     opa_q     <= dividend;
                     opb_q     <= divisor;
                     state     <= S_NORM;
                     norm_load <= 1'b1;
                     in_ready  <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
               S_NORM: begin
                  if (opa_zero) begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                     res_zero  <= 1'b1;
                  end else if (opb_zero) begin
                     state        <= S_DONE;
                     out_valid    <= 1'b1;
                     res_div_zero <= 1'b1;
                  end else begin
                     state      <= S_ITER;
                     cnt        <= '0;
                     iter_en    <= 1'b1;
                     iter_first <= 1'b1;
                     iter_idx   <= '0;
                  end
               end
               S_ITER: begin
                  if (cnt == LAST_IDX) begin
                     state <= S_FIX;
                     cnt   <= '0;
                  end else begin
                     cnt      <= cnt + 6'd1;
                     iter_en  <= 1'b1;
                     iter_idx <= cnt + 6'd1;
                  end
               end
               S_FIX: begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
               end
               S_DONE: begin
                  if (out_ready) begin
                     state        <= S_IDLE;
                     in_ready     <= 1'b1;
                     busy         <= 1'b0;
                     out_valid    <= 1'b0;
                     res_zero     <= 1'b0;
                     res_div_zero <= 1'b0;
                  end
               end
               default: begin
                  state    <= S_IDLE;
                  cnt      <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

`ifndef SYNTHESIS
   a_onehot_activity : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({norm_load, iter_en, (state == S_FIX), out_valid}));
   a_first_with_en : assert property (@(posedge clk) disable iff (!rst_n)
      iter_first |-> iter_en);
   a_idx_idle_zero : assert property (@(posedge clk) disable iff (!rst_n)
      !iter_en |-> (iter_idx == 6'd0));
   a_no_accept_busy : assert property (@(posedge clk) disable iff (!rst_n)
      in_ready == !busy);
   a_result_held : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(res_zero) && $stable(res_div_zero)));
`endif

endmodule

// File: tb/tb_srt_div_ctrl.sv
// Directed bench for srt_div_ctrl: cycle-by-cycle compare against a schedule model plus literal timing checks.
module tb_srt_div_ctrl;

   localparam int ITERS = 26;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] opa_q;
   logic [31:0] opb_q;
   logic        flush;
   logic        norm_load;
   logic        iter_en;
   logic        iter_first;
   logic [5:0]  iter_idx;
   logic        rem_neg;
   logic        corr_en;
   logic        out_valid;
   logic        out_ready;
   logic        res_div_zero;
   logic        res_zero;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   srt_div_ctrl #(.ITERS(ITERS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .opa_q(opa_q), .opb_q(opb_q),
      .flush(flush), .norm_load(norm_load), .iter_en(iter_en), .iter_first(iter_first),
      .iter_idx(iter_idx), .rem_neg(rem_neg), .corr_en(corr_en), .out_valid(out_valid),
      .out_ready(out_ready), .res_div_zero(res_div_zero), .res_zero(res_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Model: one operation is described by its kind and its age in cycles since the accept edge.
   logic        m_act;
   int          m_age;
   logic [1:0]  m_kind;   // 0 normal divide, 1 zero dividend, 2 zero divisor
   logic [31:0] m_opa;
   logic [31:0] m_opb;

   function automatic logic e_ov();
      return m_act && ((m_kind != 2'd0) ? (m_age >= 2) : (m_age >= ITERS + 3));
   endfunction

   function automatic logic e_iter();
      return m_act && (m_kind == 2'd0) && (m_age >= 2) && (m_age <= ITERS + 1);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act = 1'b0; m_age = 0; m_kind = 2'd0; m_opa = '0; m_opb = '0;
      end else if (m_act) begin
         if (flush) m_act = 1'b0;
         else if (e_ov() && out_ready) m_act = 1'b0;
         else m_age++;
      end else if (in_valid && !flush) begin
         m_act = 1'b1;
         m_age = 1;
         m_opa = dividend;
         m_opb = divisor;
         if (dividend[30:0] == 31'd0) m_kind = 2'd1;
         else if (divisor[30:0] == 31'd0) m_kind = 2'd2;
         else m_kind = 2'd0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready",     32'(in_ready),     32'(!m_act));
         check("busy",         32'(busy),         32'(m_act));
         check("norm_load",    32'(norm_load),    32'(m_act && (m_age == 1)));
         check("iter_en",      32'(iter_en),      32'(e_iter()));
         check("iter_first",   32'(iter_first),   32'(e_iter() && (m_age == 2)));
         check("iter_idx",     32'(iter_idx),     e_iter() ? 32'(m_age - 2) : 32'd0);
         check("corr_en",      32'(corr_en),      32'(m_act && (m_kind == 2'd0) && (m_age == ITERS + 2) && rem_neg));
         check("out_valid",    32'(out_valid),    32'(e_ov()));
         check("res_zero",     32'(res_zero),     32'(e_ov() && (m_kind == 2'd1)));
         check("res_div_zero", 32'(res_div_zero), 32'(e_ov() && (m_kind == 2'd2)));
         check("opa_q",        opa_q,             m_opa);
         check("opb_q",        opb_q,             m_opb);
      end
   end

   int o_norm, o_first, o_last, o_niter, o_nfirst, o_ov, o_corr, o_ncorr;

   // Called at posedge+1 of the accept edge; cycle numbering matches the accept edge as cycle 0.
   task automatic observe(input int maxc);
      o_norm = -1; o_first = -1; o_last = -1; o_niter = 0; o_nfirst = 0;
      o_ov = -1; o_corr = -1; o_ncorr = 0;
      for (int c = 1; c <= maxc; c++) begin
         @(negedge clk);
         if (norm_load && (o_norm < 0)) o_norm = c;
         if (iter_en) begin
            if (o_first < 0) o_first = c;
            o_last = c;
            o_niter++;
         end
         if (iter_first) o_nfirst++;
         if (corr_en) begin o_ncorr++; o_corr = c; end
         if (out_valid) begin o_ov = c; break; end
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      dividend = a; divisor = b; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && (n < 100)) begin @(negedge clk); n++; end
      if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; dividend = $urandom; divisor = $urandom;
   endtask

   task automatic finish_hs();
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0;
      flush = 1'b0; rem_neg = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_opa", opa_q, 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Async reset during step 5
      send(32'h40C00000, 32'h40000000);
      repeat (7) @(negedge clk);
      check("t1_idx5", 32'(iter_idx), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      check("t1_iter_en", 32'(iter_en), 32'd0);
      check("t1_in_ready", 32'(in_ready), 32'd1);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 6.0 / 2.0 full schedule
      send(32'h40C00000, 32'h40000000);
      observe(40);
      check("t2_norm_at", 32'(o_norm), 32'd1);
      check("t2_first_iter", 32'(o_first), 32'd2);
      check("t2_last_iter", 32'(o_last), 32'd27);
      check("t2_n_iter", 32'(o_niter), 32'd26);
      check("t2_n_first", 32'(o_nfirst), 32'd1);
      check("t2_ov_at", 32'(o_ov), 32'd29);
      check("t2_res", {30'd0, res_zero, res_div_zero}, 32'd0);
      finish_hs();

      // Special cases
      send(32'h3F800000, 32'h00000000);
      observe(10);
      check("t3_dz_ov_at", 32'(o_ov), 32'd2);
      check("t3_dz_flags", {30'd0, res_zero, res_div_zero}, 32'd1);
      check("t3_dz_niter", 32'(o_niter), 32'd0);
      finish_hs();
      send(32'h80000000, 32'h3F800000);
      observe(10);
      check("t3_z_ov_at", 32'(o_ov), 32'd2);
      check("t3_z_flags", {30'd0, res_zero, res_div_zero}, 32'd2);
      finish_hs();

      // Backpressure with ignored input pulses
      out_ready = 1'b0;
      send(32'h40C00000, 32'h40000000);
      observe(40);
      check("t4_ov_at", 32'(o_ov), 32'd29);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = i[0];
         dividend = 32'h12345678;
         divisor = 32'h3F800000;
      end
      check("t4_opa_held", opa_q, 32'h40C00000);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("t4_hs_in_ready", 32'(in_ready), 32'd0);
      check("t4_hs_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_after_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Remainder correction
      rem_neg = 1'b1;
      send(32'h3F800000, 32'h40400000);
      observe(40);
      check("t5_corr_at", 32'(o_corr), 32'd28);
      check("t5_n_corr", 32'(o_ncorr), 32'd1);
      finish_hs();
      rem_neg = 1'b0;
      send(32'h3F800000, 32'h40400000);
      observe(40);
      check("t5_no_corr", 32'(o_ncorr), 32'd0);
      finish_hs();

      // Flush mid-iteration, then flush in IDLE
      send(32'h40C00000, 32'h40000000);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_out_valid", 32'(out_valid), 32'd0);
      observe(30);
      check("t6_no_ov", 32'(o_ov), 32'hFFFFFFFF);
      @(posedge clk); #1;
      in_valid = 1'b1; flush = 1'b1; dividend = 32'h12345678; divisor = 32'h3F800000;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("t6_idle_busy", 32'(busy), 32'd0);
      check("t6_opa_kept", opa_q, 32'h40C00000);

      // Flush beats out_ready in DONE
      out_ready = 1'b0;
      @(posedge clk); #1;
      send(32'h3F800000, 32'h00000000);
      observe(10);
      check("t7_ov_at", 32'(o_ov), 32'd2);
      @(posedge clk); #1;
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("t7_dropped", {30'd0, out_valid, res_div_zero}, 32'd0);
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
